// File: rtl/fpu_utils_rsinfo_pipe_if.sv
// Shared FPU format/type package and the handshake interface of the operand-info pipeline stage.
// The package lives here so it is compiled ahead of both the interface and the stage.
package fpu_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
  } fp_info_t;

  typedef struct packed {
    logic any_inf;
    logic any_nan;
    logic any_signalling_nan;
  } fp_info_any_t;

  function automatic int unsigned exp_bits(input fp_format_e fmt);
    case (fmt)
      FP64:      return 11;
      FP16, FP8: return 5;
      default:   return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(input fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(input fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

endpackage

interface fpu_utils_rsinfo_pipe_if #(
  parameter int unsigned RS_NUM  = 3,
  parameter int unsigned REG_LEN = 32
);
  logic                               i_valid;
  logic                               o_ready;
  logic [RS_NUM:1][REG_LEN-1:0]       i_rs;
  logic                               i_clr_sticky;
  logic                               o_valid;
  logic                               i_ready;
  logic [RS_NUM:1][REG_LEN-1:0]       o_rs;
  fpu_pkg::fp_info_t [RS_NUM:1]       o_rs_info;
  fpu_pkg::fp_info_any_t              o_rs_info_any;
  logic [RS_NUM:1][9:0]               o_rs_class;
  logic                               o_sticky_snan;

  // Upstream producer and downstream consumer seen as one agent.
  modport master (
    output i_valid, i_rs, i_clr_sticky, i_ready,
    input  o_ready, o_valid, o_rs, o_rs_info, o_rs_info_any, o_rs_class, o_sticky_snan
  );

  modport slave (
    input  i_valid, i_rs, i_clr_sticky, i_ready,
    output o_ready, o_valid, o_rs, o_rs_info, o_rs_info_any, o_rs_class, o_sticky_snan
  );
endinterface

// File: rtl/fpu_utils_rsinfo_pipe.sv
// Registered, handshaked operand classifier (per-operand info, fclass mask, sticky sNaN flag).
// Optional NaN-box checking of the upper operand bits is enabled with macro FPU_RSINFO_NANBOX_EN.
module fpu_utils_rsinfo_pipe
  import fpu_pkg::*;
#(
  parameter fp_format_e  FP_FMT  = fp_format_e'(0),
  parameter int unsigned RS_NUM  = 3,
  parameter int unsigned REG_LEN = fp_width(FP_FMT),
  parameter bit          SKID    = 1'b1
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  fpu_utils_rsinfo_pipe_if.slave bus
);

  localparam int unsigned EXP_BITS = exp_bits(FP_FMT);
  localparam int unsigned MAN_BITS = man_bits(FP_FMT);
  localparam int unsigned FLEN     = fp_width(FP_FMT);

  localparam logic [FLEN-1:0] CANON_QNAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

  typedef struct packed {
    logic [RS_NUM:1][REG_LEN-1:0] rs;
    fp_info_t [RS_NUM:1]          info;
    fp_info_any_t                 any;
    logic [RS_NUM:1][9:0]         cls;
  } stage_t;

  function automatic fp_info_t classify(input logic [FLEN-1:0] v);
    logic [EXP_BITS-1:0] expo;
    logic [MAN_BITS-1:0] man;
    logic                exp_ones;
    logic                exp_zero;
    logic                man_zero;
    fp_info_t            info;
    expo     = v[FLEN-2 -: EXP_BITS];
    man      = v[MAN_BITS-1:0];
    exp_ones = &expo;
    exp_zero = ~|expo;
    man_zero = ~|man;
    info               = '0;
    info.is_normal     = !exp_ones && !exp_zero;
    info.is_inf        = exp_ones && man_zero;
    info.is_nan        = exp_ones && !man_zero;
    info.is_zero       = exp_zero && man_zero;
    info.is_subnormal  = exp_zero && !man_zero;
    info.is_signalling = info.is_nan && !man[MAN_BITS-1];
    info.is_quiet      = info.is_nan && man[MAN_BITS-1];
    return info;
  endfunction

  function automatic logic [9:0] fclass(input logic sign, input fp_info_t info);
    logic [9:0] cls;
    cls    = '0;
    cls[0] = sign && info.is_inf;
    cls[1] = sign && info.is_normal;
    cls[2] = sign && info.is_subnormal;
    cls[3] = sign && info.is_zero;
    cls[4] = !sign && info.is_zero;
    cls[5] = !sign && info.is_subnormal;
    cls[6] = !sign && info.is_normal;
    cls[7] = !sign && info.is_inf;
    cls[8] = info.is_signalling;
    cls[9] = info.is_quiet;
    return cls;
  endfunction

  logic [RS_NUM:1][FLEN-1:0] lane_val;
  fp_info_t [RS_NUM:1]       lane_info;
  logic [RS_NUM:1][9:0]      lane_cls;

  for (genvar k = 1; k <= RS_NUM; k++) begin : g_lane
`ifdef FPU_RSINFO_NANBOX_EN
    if (REG_LEN > FLEN) begin : g_box
      // An improperly boxed narrow value reads as the canonical quiet NaN.
      assign lane_val[k] = (&bus.i_rs[k][REG_LEN-1:FLEN]) ? bus.i_rs[k][FLEN-1:0] : CANON_QNAN;
    end else begin : g_raw
      assign lane_val[k] = bus.i_rs[k][FLEN-1:0];
    end
`else
    assign lane_val[k] = bus.i_rs[k][FLEN-1:0];
`endif
    assign lane_info[k] = classify(lane_val[k]);
    assign lane_cls[k]  = fclass(lane_val[k][FLEN-1], lane_info[k]);
  end

  stage_t d;

  // NOTE: every field gets a default before the loop so the block stays purely combinational.
  always_comb begin
    d      = '0;
    d.rs   = bus.i_rs;
    d.info = lane_info;
    d.cls  = lane_cls;
    for (int k = 1; k <= RS_NUM; k++) begin
      d.any.any_inf            = d.any.any_inf | lane_info[k].is_inf;
      d.any.any_nan            = d.any.any_nan | lane_info[k].is_nan;
      d.any.any_signalling_nan = d.any.any_signalling_nan | lane_info[k].is_signalling;
    end
  end

  stage_t main_q;
  stage_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   ready_q;
  logic   sticky_q;
  logic   ready;
  logic   in_xfer;
  logic   out_xfer;

  assign ready    = SKID ? ready_q : (!main_valid || bus.i_ready);
  assign in_xfer  = bus.i_valid && ready;
  assign out_xfer = main_valid && bus.i_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      main_valid <= 1'b0;
      main_q     <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      sticky_q   <= 1'b0;
    end else begin
      if (out_xfer && main_q.any.any_signalling_nan) begin
        sticky_q <= 1'b1;
      end else if (bus.i_clr_sticky) begin
        sticky_q <= 1'b0;
      end

      if (!main_valid || out_xfer) begin
        if (SKID && skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
          ready_q    <= 1'b1;
        end else if (in_xfer) begin
          main_q     <= d;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (SKID && in_xfer) begin
        // Main entry is stalled: park the newcomer and stop accepting.
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end
    end
  end

  // NOTE: skid payload needs no reset; it is only observed through skid_valid, which is reset.
  always_ff @(posedge i_clk) begin
    if (SKID && in_xfer && main_valid && !out_xfer) begin
      skid_q <= d;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_valid       = main_valid;
  assign bus.o_rs          = main_q.rs;
  assign bus.o_rs_info     = main_q.info;
  assign bus.o_rs_info_any = main_q.any;
  assign bus.o_rs_class    = main_q.cls;
  assign bus.o_sticky_snan = sticky_q;

endmodule

// File: tb/tb_fpu_utils_rsinfo_pipe.sv
// Self-checking bench: FP32 x3 skid stage with a queue scoreboard, plus a 64-bit NaN-box lane.
module tb_fpu_utils_rsinfo_pipe;
  import fpu_pkg::*;

  typedef logic [3:1][31:0] ops_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_utils_rsinfo_pipe_if #(.RS_NUM(3), .REG_LEN(32)) bus ();
  fpu_utils_rsinfo_pipe_if #(.RS_NUM(1), .REG_LEN(64)) bus64 ();

  fpu_utils_rsinfo_pipe #(.FP_FMT(FP32), .RS_NUM(3), .REG_LEN(32), .SKID(1'b1)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  fpu_utils_rsinfo_pipe #(.FP_FMT(FP32), .RS_NUM(1), .REG_LEN(64), .SKID(1'b0)) dut64 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus64)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  ops_t exp_q[$];
  bit   model_sticky = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fclass index from sign/exponent/mantissa fields read as plain integers.
  function automatic int class_idx(input logic [31:0] v);
    int unsigned e;
    int unsigned m;
    bit          s;
    s = v[31];
    e = 32'(v[30:23]);
    m = 32'(v[22:0]);
    if (e == 255) return (m == 0) ? (s ? 0 : 7) : ((m >= 32'h40_0000) ? 9 : 8);
    if (e == 0)   return (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    return s ? 1 : 6;
  endfunction

  function automatic logic [9:0] model_class(input logic [31:0] v);
    return 10'(1) << class_idx(v);
  endfunction

  function automatic fp_info_t model_info(input int idx);
    fp_info_t mi;
    mi               = '0;
    mi.is_inf        = (idx == 0 || idx == 7);
    mi.is_normal     = (idx == 1 || idx == 6);
    mi.is_subnormal  = (idx == 2 || idx == 5);
    mi.is_zero       = (idx == 3 || idx == 4);
    mi.is_nan        = (idx == 8 || idx == 9);
    mi.is_signalling = (idx == 8);
    mi.is_quiet      = (idx == 9);
    return mi;
  endfunction

  function automatic logic [9:0] model_class64(input logic [63:0] v);
    logic [31:0] hi;
    hi = v[63:32];
`ifdef FPU_RSINFO_NANBOX_EN
    if (hi != 32'hFFFF_FFFF) return 10'h200;
`else
    if (hi == 32'h0) return model_class(v[31:0]);
`endif
    return model_class(v[31:0]);
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] pool [0:11];
    pool = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h807F_FFFF,
             32'h3F80_0000, 32'hBF80_0000, 32'h7F80_0000, 32'hFF80_0000,
             32'h7F80_0001, 32'hFFA0_0000, 32'h7FC0_0000, 32'hFFC0_0001};
    if ($urandom_range(0, 1) == 1) return $urandom();
    return pool[$urandom_range(0, 11)];
  endfunction

  function automatic ops_t rand_ops();
    ops_t r;
    for (int k = 1; k <= 3; k++) r[k] = rand_val();
    return r;
  endfunction

  task automatic compare_out(input ops_t e);
    fp_info_any_t ma;
    int           idx;
    ma = '0;
    check("o_rs", 128'(bus.o_rs), 128'(e));
    for (int k = 1; k <= 3; k++) begin
      idx = class_idx(e[k]);
      check($sformatf("class_lane%0d", k), 128'(bus.o_rs_class[k]), 128'(model_class(e[k])));
      check($sformatf("info_lane%0d", k), 128'(bus.o_rs_info[k]), 128'(model_info(idx)));
      ma.any_inf            = ma.any_inf | (idx == 0 || idx == 7);
      ma.any_nan            = ma.any_nan | (idx >= 8);
      ma.any_signalling_nan = ma.any_signalling_nan | (idx == 8);
    end
    check("info_any", 128'(bus.o_rs_info_any), 128'(ma));
  endtask

  // One clock of the main DUT: drive, score any transfers, then check state after the edge.
  task automatic cycle(input bit v, input ops_t rs, input bit rdy, input bit clr);
    bit   in_x;
    bit   out_x;
    bit   snan;
    ops_t e;
    bus.i_valid      = v;
    bus.i_rs         = rs;
    bus.i_ready      = rdy;
    bus.i_clr_sticky = clr;
    #1;
    in_x  = v && bus.o_ready;
    out_x = bus.o_valid && rdy;
    snan  = 1'b0;
    if (out_x) begin
      check("out_expected", 128'(exp_q.size() > 0), 128'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_out(e);
        for (int k = 1; k <= 3; k++) if (class_idx(e[k]) == 8) snan = 1'b1;
      end
    end
    if (in_x) exp_q.push_back(rs);
    if (out_x && snan) model_sticky = 1'b1;
    else if (clr)      model_sticky = 1'b0;
    @(posedge clk);
    #1;
    check("sticky", 128'(bus.o_sticky_snan), 128'(model_sticky));
    check("o_valid", 128'(bus.o_valid), 128'(exp_q.size() > 0));
    check("o_ready", 128'(bus.o_ready), 128'(exp_q.size() < 2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ops_t t1, t2, a, b, c;
    t1 = {32'h7F80_0001, 32'h7FC0_0000, 32'hFF80_0000};
    t2 = {32'h0000_0001, 32'h8000_0000, 32'h3F80_0000};
    a  = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    b  = {32'hBF80_0000, 32'h0000_0000, 32'h7F80_0000};
    c  = {32'h0000_0010, 32'hFFC0_0000, 32'h8000_0001};

    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_rs = '0; bus.i_ready = 1'b0; bus.i_clr_sticky = 1'b0;
    bus64.i_valid = 1'b0; bus64.i_rs = '0; bus64.i_ready = 1'b0; bus64.i_clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(bus.o_valid), 128'(0));
    check("rst_ready", 128'(bus.o_ready), 128'(1));
    check("rst_sticky", 128'(bus.o_sticky_snan), 128'(0));
    check("rst_rs", 128'(bus.o_rs), 128'(0));
    check("rst_class", 128'(bus.o_rs_class), 128'(0));
    rst_n = 1'b1;

    // Mixed sNaN / qNaN / -inf operands.
    cycle(1'b1, t1, 1'b1, 1'b0);
    check("t1_class3", 128'(bus.o_rs_class[3]), 128'(10'h100));
    check("t1_class2", 128'(bus.o_rs_class[2]), 128'(10'h200));
    check("t1_class1", 128'(bus.o_rs_class[1]), 128'(10'h001));
    check("t1_any", 128'(bus.o_rs_info_any), 128'(3'b111));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t1_sticky_set", 128'(bus.o_sticky_snan), 128'(1));
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("t1_sticky_clr", 128'(bus.o_sticky_snan), 128'(0));

    // Subnormal, negative zero, normal.
    cycle(1'b1, t2, 1'b1, 1'b0);
    check("t2_class3", 128'(bus.o_rs_class[3]), 128'(10'h020));
    check("t2_class2", 128'(bus.o_rs_class[2]), 128'(10'h008));
    check("t2_class1", 128'(bus.o_rs_class[1]), 128'(10'h040));
    check("t2_sub", 128'(bus.o_rs_info[3].is_subnormal), 128'(1));
    check("t2_zero", 128'(bus.o_rs_info[2].is_zero), 128'(1));
    check("t2_norm", 128'(bus.o_rs_info[1].is_normal), 128'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Set and clear together: set wins; a lone clear afterwards drops it.
    cycle(1'b1, t1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("sticky_set_wins", 128'(bus.o_sticky_snan), 128'(1));
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("sticky_lone_clr", 128'(bus.o_sticky_snan), 128'(0));

    // Stall while sending A,B,C: C waits upstream, then A,B,C stream out back to back.
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    check("skid_full_ready", 128'(bus.o_ready), 128'(0));
    cycle(1'b1, c, 1'b0, 1'b0);
    check("skid_hold_a", 128'(bus.o_rs), 128'(a));
    cycle(1'b1, c, 1'b1, 1'b0);
    check("skid_next_b", 128'(bus.o_rs), 128'(b));
    cycle(1'b1, c, 1'b1, 1'b0);
    check("skid_next_c", 128'(bus.o_rs), 128'(c));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with random backpressure and clears.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_ops(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drained", 128'(exp_q.size()), 128'(0));

    // Reset with both entries occupied and the sticky flag set.
    cycle(1'b1, t1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    check("pre_rst_sticky", 128'(bus.o_sticky_snan), 128'(1));
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_sticky = 1'b0;
    check("mid_rst_valid", 128'(bus.o_valid), 128'(0));
    check("mid_rst_ready", 128'(bus.o_ready), 128'(1));
    check("mid_rst_sticky", 128'(bus.o_sticky_snan), 128'(0));
    check("mid_rst_rs", 128'(bus.o_rs), 128'(0));
    check("mid_rst_info", 128'(bus.o_rs_info), 128'(0));
    rst_n = 1'b1;
    cycle(1'b1, t2, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 64-bit register holding FP32: NaN-box handling and the single-register variant.
    bus64.i_valid = 1'b1;
    bus64.i_rs    = 64'h0000_0000_3F80_0000;
    bus64.i_ready = 1'b1;
    @(posedge clk);
    #1;
    check("box_bad_class", 128'(bus64.o_rs_class[1]), 128'(model_class64(64'h0000_0000_3F80_0000)));
    check("box_bad_rs", 128'(bus64.o_rs), 128'(64'h0000_0000_3F80_0000));
    bus64.i_rs = 64'hFFFF_FFFF_3F80_0000;
    @(posedge clk);
    #1;
    check("box_ok_class", 128'(bus64.o_rs_class[1]), 128'(10'h040));
    check("box_ok_rs", 128'(bus64.o_rs), 128'(64'hFFFF_FFFF_3F80_0000));
    bus64.i_ready = 1'b0;
    #1;
    check("noskid_stall_ready", 128'(bus64.o_ready), 128'(0));
    @(posedge clk);
    #1;
    check("noskid_hold_rs", 128'(bus64.o_rs), 128'(64'hFFFF_FFFF_3F80_0000));
    bus64.i_ready = 1'b1;
    #1;
    check("noskid_flow_ready", 128'(bus64.o_ready), 128'(1));
    bus64.i_valid = 1'b0;
    @(posedge clk);
    #1;
    check("noskid_empty", 128'(bus64.o_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
